// File: rtl/tpu_ctrl_pkg.sv
// Shared definitions for the systolic array sequencer: FSM encodings and
// fixed geometry of the 2x2 feed schedule.
package tpu_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CLEAR,
    ST_FEED,
    ST_DRAIN,
    ST_CAPTURE,
    ST_OUT
  } state_e;

  localparam int FEED_BEATS  = 3;
  localparam int ADDR_SEL_B  = 2;
  localparam int NUM_RESULTS = 4;

endpackage

// File: rtl/systolic_ctrl_2x2_skew.sv
// Wavefront skew mux: maps feed beat k and the row-major operand registers
// onto the array edge inputs. Purely combinational; the caller registers it.
module systolic_skew_feed_2x2 #(
  parameter int WIDTH = 8
) (
  input  logic                        feed_en_i,
  input  logic [1:0]                  beat_i,
  input  logic [3:0][WIDTH-1:0]       a_op_i,
  input  logic [3:0][WIDTH-1:0]       b_op_i,
  output logic [WIDTH-1:0]            a0_o,
  output logic [WIDTH-1:0]            a1_o,
  output logic [WIDTH-1:0]            b0_o,
  output logic [WIDTH-1:0]            b1_o
);

  // NOTE: every output gets a default before the case so no path can infer a latch.
  always_comb begin
    a0_o = '0;
    a1_o = '0;
    b0_o = '0;
    b1_o = '0;
    if (feed_en_i) begin
      unique case (beat_i)
        2'd0: begin
          a0_o = a_op_i[0];
          b0_o = b_op_i[0];
        end
        2'd1: begin
          a0_o = a_op_i[1];
          a1_o = a_op_i[2];
          b0_o = b_op_i[2];
          b1_o = b_op_i[1];
        end
        2'd2: begin
          a1_o = a_op_i[3];
          b1_o = b_op_i[3];
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/systolic_ctrl_2x2.sv
// Sequencer for the 2x2 systolic array: holds operands, runs clear/feed/drain,
// captures the four results and streams them over a valid/ready port.
module systolic_ctrl_2x2
  import tpu_ctrl_pkg::*;
#(
  parameter int WIDTH        = 8,
  parameter int DRAIN_CYCLES = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 wr_en,
  input  logic [2:0]           wr_addr,
  input  logic [WIDTH-1:0]     wr_data,
  input  logic                 act_en,
  input  logic                 start,
  output logic                 busy,
  output logic                 done,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*WIDTH-1:0]   out_data,
  output logic                 arr_clear,
  output logic                 arr_activation,
  output logic [WIDTH-1:0]     arr_a0,
  output logic [WIDTH-1:0]     arr_a1,
  output logic [WIDTH-1:0]     arr_b0,
  output logic [WIDTH-1:0]     arr_b1,
  input  logic [2*WIDTH-1:0]   arr_c00,
  input  logic [2*WIDTH-1:0]   arr_c01,
  input  logic [2*WIDTH-1:0]   arr_c10,
  input  logic [2*WIDTH-1:0]   arr_c11
);

  localparam int CNT_W = $clog2(FEED_BEATS + DRAIN_CYCLES + 1);

  state_e                               state_q, state_d;
  logic [CNT_W-1:0]                     cnt_q, cnt_d;
  logic [1:0]                           idx_q, idx_d;
  logic [3:0][WIDTH-1:0]                a_op_q, b_op_q;
  logic [NUM_RESULTS-1:0][2*WIDTH-1:0]  res_q;
  logic                                 start_acc, handshake, last_hs;
  logic [WIDTH-1:0]                     feed_a0, feed_a1, feed_b0, feed_b1;

  assign handshake = out_valid && out_ready;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    idx_d     = idx_q;
    start_acc = 1'b0;
    last_hs   = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d   = ST_CLEAR;
          start_acc = 1'b1;
        end
      end
      ST_CLEAR: begin
        state_d = ST_FEED;
        cnt_d   = '0;
      end
      ST_FEED: begin
        if (cnt_q == CNT_W'(FEED_BEATS - 1)) begin
          cnt_d   = '0;
          state_d = (DRAIN_CYCLES > 0) ? ST_DRAIN : ST_CAPTURE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_DRAIN: begin
        if (cnt_q == CNT_W'(DRAIN_CYCLES - 1)) state_d = ST_CAPTURE;
        else                                   cnt_d   = cnt_q + CNT_W'(1);
      end
      ST_CAPTURE: begin
        state_d = ST_OUT;
        idx_d   = '0;
      end
      ST_OUT: begin
        if (handshake) begin
          if (idx_q == 2'd3) begin
            state_d = ST_IDLE;
            last_hs = 1'b1;
          end else begin
            idx_d = idx_q + 2'd1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Mux is driven from next-state so the registered array inputs line up
  // with the state they belong to.
  systolic_skew_feed_2x2 #(.WIDTH(WIDTH)) u_skew (
    .feed_en_i (state_d == ST_FEED),
    .beat_i    (cnt_d[1:0]),
    .a_op_i    (a_op_q),
    .b_op_i    (b_op_q),
    .a0_o      (feed_a0),
    .a1_o      (feed_a1),
    .b0_o      (feed_b0),
    .b1_o      (feed_b1)
  );

  // NOTE: state uses non-blocking assignments only; operand and result buffers
  // are small flop arrays that must read zero after reset, so they are reset too.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= ST_IDLE;
      cnt_q          <= '0;
      idx_q          <= '0;
      a_op_q         <= '0;
      b_op_q         <= '0;
      res_q          <= '0;
      busy           <= 1'b0;
      done           <= 1'b0;
      out_valid      <= 1'b0;
      out_data       <= '0;
      arr_clear      <= 1'b0;
      arr_activation <= 1'b0;
      arr_a0         <= '0;
      arr_a1         <= '0;
      arr_b0         <= '0;
      arr_b1         <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      if (wr_en && !busy) begin
        if (wr_addr[ADDR_SEL_B]) b_op_q[wr_addr[1:0]] <= wr_data;
        else                     a_op_q[wr_addr[1:0]] <= wr_data;
      end
      if (start_acc) arr_activation <= act_en;
      if (state_q == ST_CAPTURE) res_q <= {arr_c11, arr_c10, arr_c01, arr_c00};
      busy      <= (state_d != ST_IDLE);
      done      <= last_hs;
      out_valid <= (state_d == ST_OUT);
      // c00 bypasses the buffer on capture; later words come from res_q.
      if (state_q == ST_CAPTURE)      out_data <= arr_c00;
      else if (handshake && !last_hs) out_data <= res_q[idx_d];
      arr_clear <= (state_d == ST_CLEAR);
      arr_a0    <= feed_a0;
      arr_a1    <= feed_a1;
      arr_b0    <= feed_b0;
      arr_b1    <= feed_b1;
    end
  end

endmodule
